// File: rtl/vlt_vbits_collector.sv
`timescale 1ns/1ps
// Per-epoch vulnerable-bit accumulator between the vlt lookup and the SPU.
// Sums five vbits streams per epoch, then offers scaled 12-bit totals under valid/ready.
module vlt_vbits_collector #(
    parameter int unsigned EPOCH_LEN = 1024,
    parameter int unsigned OUT_SHIFT = 8,
    parameter int unsigned ACC_W     = 24
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_i,
    input  logic        vbits_v_i,
    input  logic [17:0] iq_vbits_i,
    input  logic [17:0] rob_vbits_i,
    input  logic [17:0] lq_vbits_i,
    input  logic [17:0] sq_vbits_i,
    input  logic [17:0] instbuff_vbits_i,
    output logic [11:0] total_qvbits0_o,
    output logic [11:0] total_qvbits1_o,
    output logic [11:0] total_qvbits2_o,
    output logic [11:0] total_qvbits3_o,
    output logic [11:0] total_sq_vbits_o,
    output logic [10:0] inst_count_o,
    output logic        out_v_o,
    input  logic        out_ready_i,
    output logic        sat_o,
    output logic        overrun_o
);

    localparam int unsigned NF      = 5;
    localparam int unsigned VB_W    = 18;
    localparam int unsigned RES_W   = 12;
    localparam int unsigned RES_MAX = 4095;
    localparam int unsigned IC_W    = 11;
    localparam int unsigned SUM_W   = ACC_W + 1;
    localparam int unsigned CNT_W   = $clog2(EPOCH_LEN);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EPOCH_LEN - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q [NF];
    logic [ACC_W-1:0] acc_d [NF];
    logic [ACC_W-1:0] acc_inc [NF];
    logic [RES_W:0]   scaled [NF];
    logic [RES_W-1:0] res_q [NF];
    logic [RES_W-1:0] res_d [NF];
    logic [IC_W-1:0]  icnt_q, icnt_d, icnt_inc;
    logic [IC_W-1:0]  ic_res_q, ic_res_d;
    logic             out_v_q, out_v_d;
    logic             sat_q, sat_d;
    logic             ovr_q, ovr_d;
    logic [VB_W-1:0]  vb [NF];
    logic             beat, snap, sat_any;

    // Field order: IQ, ROB, LQ, InstBuff, SQ (matches result register order).
    assign vb[0] = iq_vbits_i;
    assign vb[1] = rob_vbits_i;
    assign vb[2] = lq_vbits_i;
    assign vb[3] = instbuff_vbits_i;
    assign vb[4] = sq_vbits_i;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [VB_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    // Returns {saturated, 12-bit scaled value}.
    function automatic logic [RES_W:0] scale(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] sh;
        sh = a >> OUT_SHIFT;
        if (sh > ACC_W'(RES_MAX)) begin
            return {1'b1, {RES_W{1'b1}}};
        end
        return {1'b0, sh[RES_W-1:0]};
    endfunction

    // Next-state: epoch counting, accumulation, snapshot and handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        icnt_d   = icnt_q;
        ic_res_d = ic_res_q;
        out_v_d  = out_v_q;
        sat_d    = sat_q;
        ovr_d    = ovr_q;
        snap     = 1'b0;
        sat_any  = 1'b0;
        beat     = (state_q == S_ACCUM) && vbits_v_i;
        icnt_inc = (beat && (icnt_q != {IC_W{1'b1}})) ? icnt_q + IC_W'(1) : icnt_q;
        for (int i = 0; i < NF; i++) begin
            acc_inc[i] = beat ? sat_add(acc_q[i], vb[i]) : acc_q[i];
            scaled[i]  = scale(acc_inc[i]);
            acc_d[i]   = acc_q[i];
            res_d[i]   = res_q[i];
            sat_any    = sat_any | scaled[i][RES_W];
        end

        if (state_q == S_IDLE) begin
            cnt_d  = '0;
            icnt_d = '0;
            for (int i = 0; i < NF; i++) begin
                acc_d[i] = '0;
            end
            if (enable_i) begin
                state_d = S_ACCUM;
            end
        end else begin
            icnt_d = icnt_inc;
            for (int i = 0; i < NF; i++) begin
                acc_d[i] = acc_inc[i];
            end
            if (!enable_i) begin
                snap    = 1'b1;
                state_d = S_IDLE;
                cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
                snap  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A snapshot includes this cycle's beat and restarts the epoch sums.
        if (snap) begin
            for (int i = 0; i < NF; i++) begin
                acc_d[i] = '0;
                res_d[i] = scaled[i][RES_W-1:0];
            end
            icnt_d   = '0;
            ic_res_d = icnt_inc;
            sat_d    = sat_any;
            out_v_d  = 1'b1;
            if (out_v_q && !out_ready_i) begin
                ovr_d = 1'b1;
            end
        end else if (out_v_q && out_ready_i) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            icnt_q   <= '0;
            ic_res_q <= '0;
            out_v_q  <= 1'b0;
            sat_q    <= 1'b0;
            ovr_q    <= 1'b0;
            for (int i = 0; i < NF; i++) begin
                acc_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            icnt_q   <= icnt_d;
            ic_res_q <= ic_res_d;
            out_v_q  <= out_v_d;
            sat_q    <= sat_d;
            ovr_q    <= ovr_d;
            for (int i = 0; i < NF; i++) begin
                acc_q[i] <= acc_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    assign total_qvbits0_o  = res_q[0];
    assign total_qvbits1_o  = res_q[1];
    assign total_qvbits2_o  = res_q[2];
    assign total_qvbits3_o  = res_q[3];
    assign total_sq_vbits_o = res_q[4];
    assign inst_count_o     = ic_res_q;
    assign out_v_o          = out_v_q;
    assign sat_o            = sat_q;
    assign overrun_o        = ovr_q;

endmodule

// File: tb/tb_vlt_vbits_collector.sv
`timescale 1ns/1ps
// Bench for vlt_vbits_collector: two instances (OUT_SHIFT 0 and 8, 16-cycle epochs)
// driven from a shared table, hand sequences, and random traffic against an epoch-sum model.
module tb_vlt_vbits_collector;

    localparam int EPOCH = 16;
    localparam longint CAP0 = (64'd1 << 24) - 1;
    localparam longint CAP8 = (64'd1 << 19) - 1;

    logic clock;
    logic reset, enable_i, vbits_v_i, out_ready_i;
    logic [17:0] iq, rob, lq, sq, ib;

    logic [11:0] r0 [5];
    logic [11:0] r8 [5];
    logic [10:0] ic0, ic8;
    logic        v0, v8, sat0, sat8, ovr0, ovr8;
    logic [73:0] obs0, obs8;

    int vectors = 0;
    int miscompares = 0;

    vlt_vbits_collector #(.EPOCH_LEN(EPOCH), .OUT_SHIFT(0), .ACC_W(24)) dut (
        .clock(clock), .reset(reset), .enable_i(enable_i), .vbits_v_i(vbits_v_i),
        .iq_vbits_i(iq), .rob_vbits_i(rob), .lq_vbits_i(lq), .sq_vbits_i(sq),
        .instbuff_vbits_i(ib),
        .total_qvbits0_o(r0[0]), .total_qvbits1_o(r0[1]), .total_qvbits2_o(r0[2]),
        .total_qvbits3_o(r0[3]), .total_sq_vbits_o(r0[4]), .inst_count_o(ic0),
        .out_v_o(v0), .out_ready_i(out_ready_i), .sat_o(sat0), .overrun_o(ovr0));

    vlt_vbits_collector #(.EPOCH_LEN(EPOCH), .OUT_SHIFT(8), .ACC_W(19)) dut8 (
        .clock(clock), .reset(reset), .enable_i(enable_i), .vbits_v_i(vbits_v_i),
        .iq_vbits_i(iq), .rob_vbits_i(rob), .lq_vbits_i(lq), .sq_vbits_i(sq),
        .instbuff_vbits_i(ib),
        .total_qvbits0_o(r8[0]), .total_qvbits1_o(r8[1]), .total_qvbits2_o(r8[2]),
        .total_qvbits3_o(r8[3]), .total_sq_vbits_o(r8[4]), .inst_count_o(ic8),
        .out_v_o(v8), .out_ready_i(out_ready_i), .sat_o(sat8), .overrun_o(ovr8));

    assign obs0 = {r0[0], r0[1], r0[2], r0[3], r0[4], ic0, v0, sat0, ovr0};
    assign obs8 = {r8[0], r8[1], r8[2], r8[3], r8[4], ic8, v8, sat8, ovr8};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: true per-epoch totals; caps and scaling applied only when an epoch closes.
    longint m_sum [5];
    int     m_n, m_phase;
    bit     m_act;
    int     e0 [5];
    int     e8 [5];
    int     e_ic;
    bit     e_v, e_s0, e_s8, e_ovr;

    function automatic longint lmin(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_snapshot();
        longint c0, c8;
        e_s0 = 1'b0;
        e_s8 = 1'b0;
        for (int f = 0; f < 5; f++) begin
            c0 = lmin(m_sum[f], CAP0);
            c8 = lmin(m_sum[f], CAP8) / 256;
            e0[f] = int'(lmin(c0, 4095));
            e8[f] = int'(lmin(c8, 4095));
            e_s0 = e_s0 | (c0 > 4095);
            e_s8 = e_s8 | (c8 > 4095);
            m_sum[f] = 0;
        end
        e_ic = int'(lmin(longint'(m_n), 2047));
        m_n = 0;
        if (e_v && !out_ready_i) e_ovr = 1'b1;
        e_v = 1'b1;
    endtask

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_act = 1'b0; m_phase = 0; m_n = 0;
            e_ic = 0; e_v = 1'b0; e_s0 = 1'b0; e_s8 = 1'b0; e_ovr = 1'b0;
            for (int f = 0; f < 5; f++) begin
                m_sum[f] = 0; e0[f] = 0; e8[f] = 0;
            end
        end else if (!m_act) begin
            if (e_v && out_ready_i) e_v = 1'b0;
            if (enable_i) begin
                m_act = 1'b1;
                m_phase = 0;
            end
        end else begin
            if (vbits_v_i) begin
                m_sum[0] = m_sum[0] + longint'(iq);
                m_sum[1] = m_sum[1] + longint'(rob);
                m_sum[2] = m_sum[2] + longint'(lq);
                m_sum[3] = m_sum[3] + longint'(ib);
                m_sum[4] = m_sum[4] + longint'(sq);
                m_n = m_n + 1;
            end
            if (!enable_i || (m_phase % EPOCH == EPOCH - 1)) model_snapshot();
            else if (e_v && out_ready_i) e_v = 1'b0;
            m_phase = m_phase + 1;
            if (!enable_i) m_act = 1'b0;
        end
    end

    function automatic logic [11:0] ef(input bit w8, input int f);
        return w8 ? 12'(e8[f]) : 12'(e0[f]);
    endfunction

    function automatic logic [73:0] exp_obs(input bit w8);
        return {ef(w8, 0), ef(w8, 1), ef(w8, 2), ef(w8, 3), ef(w8, 4),
                11'(e_ic), e_v, (w8 ? e_s8 : e_s0), e_ovr};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic zero_vb();
        iq = '0; rob = '0; lq = '0; sq = '0; ib = '0;
    endtask

    // Leave ACCUM (closing an empty epoch) and drain the pending snapshot.
    task automatic go_idle();
        enable_i = 1'b0; vbits_v_i = 1'b0; out_ready_i = 1'b1;
        tick();
        tick();
        out_ready_i = 1'b0;
    endtask

    function automatic logic [17:0] rnd18();
        case ($urandom_range(0, 3))
            0:       return 18'($urandom_range(0, 63));
            1:       return 18'($urandom_range(0, 2000));
            2:       return 18'($urandom);
            default: return 18'h3FFFF;
        endcase
    endfunction

    typedef struct {
        int               nb;
        logic [17:0]      iq, rob, lq, ib, sq;
        logic [4:0][11:0] e0, e8;  // index 4 = IQ ... index 0 = SQ
        logic [10:0]      ic;
        logic             s0, s8;
    } vec_t;

    vec_t tbl [6];

    task automatic run_vec(input vec_t v, input int t);
        enable_i = 1'b1; out_ready_i = 1'b0; vbits_v_i = 1'b0;
        tick();
        for (int k = 0; k < EPOCH; k++) begin
            vbits_v_i = (k < v.nb);
            if (k < v.nb) begin
                iq = v.iq; rob = v.rob; lq = v.lq; ib = v.ib; sq = v.sq;
            end else begin
                iq = rnd18(); rob = rnd18(); lq = rnd18(); ib = rnd18(); sq = rnd18();
            end
            tick();
            if (k == EPOCH - 2) check($sformatf("vec%0d_early_valid", t), 80'(v0), 80'd0);
        end
        vbits_v_i = 1'b0;
        for (int f = 0; f < 5; f++) begin
            check($sformatf("vec%0d_field%0d_shift0", t, f), 80'(r0[f]), 80'(v.e0[4-f]));
            check($sformatf("vec%0d_field%0d_shift8", t, f), 80'(r8[f]), 80'(v.e8[4-f]));
        end
        check($sformatf("vec%0d_count", t), 80'({ic0, ic8}), 80'({v.ic, v.ic}));
        check($sformatf("vec%0d_valid", t), 80'({v0, v8}), 80'(2'b11));
        check($sformatf("vec%0d_sat", t), 80'({sat0, sat8}), 80'({v.s0, v.s8}));
        check($sformatf("vec%0d_overrun", t), 80'({ovr0, ovr8}), 80'd0);
        go_idle();
    endtask

    int lat;

    initial begin
        reset = 1'b0; enable_i = 1'b0; vbits_v_i = 1'b0; out_ready_i = 1'b0;
        zero_vb();
        repeat (2) tick();
        check("reset_dut0", 80'(obs0), 80'd0);
        check("reset_dut8", 80'(obs8), 80'd0);
        reset = 1'b1;
        tick();

        tbl[0] = '{nb:4, iq:18'd100, rob:18'd0, lq:18'd0, ib:18'd0, sq:18'd7,
                   e0:{12'd400, 12'd0, 12'd0, 12'd0, 12'd28},
                   e8:{12'd1, 12'd0, 12'd0, 12'd0, 12'd0}, ic:11'd4, s0:1'b0, s8:1'b0};
        tbl[1] = '{nb:1, iq:18'd0, rob:18'd0, lq:18'd5000, ib:18'd0, sq:18'd0,
                   e0:{12'd0, 12'd0, 12'd4095, 12'd0, 12'd0},
                   e8:{12'd0, 12'd0, 12'd19, 12'd0, 12'd0}, ic:11'd1, s0:1'b1, s8:1'b0};
        tbl[2] = '{nb:16, iq:18'h3FFFF, rob:18'h3FFFF, lq:18'h3FFFF, ib:18'h3FFFF, sq:18'h3FFFF,
                   e0:{12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095},
                   e8:{12'd2047, 12'd2047, 12'd2047, 12'd2047, 12'd2047},
                   ic:11'd16, s0:1'b1, s8:1'b0};
        tbl[3] = '{nb:0, iq:18'd0, rob:18'd0, lq:18'd0, ib:18'd0, sq:18'd0,
                   e0:'0, e8:'0, ic:11'd0, s0:1'b0, s8:1'b0};
        tbl[4] = '{nb:10, iq:18'd3, rob:18'd1000, lq:18'd0, ib:18'd12, sq:18'd409,
                   e0:{12'd30, 12'd4095, 12'd0, 12'd120, 12'd4090},
                   e8:{12'd0, 12'd39, 12'd0, 12'd0, 12'd15}, ic:11'd10, s0:1'b1, s8:1'b0};
        tbl[5] = '{nb:16, iq:18'd0, rob:18'd0, lq:18'd0, ib:18'd0, sq:18'd256,
                   e0:{12'd0, 12'd0, 12'd0, 12'd0, 12'd4095},
                   e8:{12'd0, 12'd0, 12'd0, 12'd0, 12'd16}, ic:11'd16, s0:1'b1, s8:1'b0};
        for (int t = 0; t < 6; t++) run_vec(tbl[t], t);

        // Beat on the epoch-end cycle belongs to the closing epoch, the next to the new one.
        zero_vb(); enable_i = 1'b1; out_ready_i = 1'b0; vbits_v_i = 1'b0;
        tick();
        repeat (15) tick();
        vbits_v_i = 1'b1; rob = 18'd5;
        tick();
        check("bnd_first_rob", 80'(r0[1]), 80'd5);
        check("bnd_first_valid", 80'(v0), 80'd1);
        rob = 18'd9; out_ready_i = 1'b1;
        tick();
        vbits_v_i = 1'b0; out_ready_i = 1'b0;
        check("bnd_transfer_clears", 80'(v0), 80'd0);
        repeat (15) tick();
        check("bnd_second_rob", 80'(r0[1]), 80'd9);
        check("bnd_second_valid", 80'(v0), 80'd1);
        go_idle();

        // Disable mid-epoch: partial snapshot, then the block sits idle.
        zero_vb(); enable_i = 1'b1;
        tick();
        vbits_v_i = 1'b1; ib = 18'd2;
        repeat (3) tick();
        vbits_v_i = 1'b0;
        repeat (2) tick();
        enable_i = 1'b0;
        tick();
        check("dis_instbuff", 80'(r0[3]), 80'd6);
        check("dis_count", 80'(ic0), 80'd3);
        check("dis_valid", 80'(v0), 80'd1);
        vbits_v_i = 1'b1; ib = 18'd7;
        repeat (20) tick();
        check("dis_idle_hold", 80'({r0[3], ic0, v0, ovr0}), 80'({12'd6, 11'd3, 1'b1, 1'b0}));
        vbits_v_i = 1'b0; out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("dis_drained", 80'(v0), 80'd0);

        // Backpressure across two epochs.
        zero_vb(); enable_i = 1'b1;
        tick();
        vbits_v_i = 1'b1; iq = 18'd10;
        tick();
        vbits_v_i = 1'b0;
        repeat (15) tick();
        check("bp_first", 80'({r0[0], v0, ovr0}), 80'({12'd10, 1'b1, 1'b0}));
        vbits_v_i = 1'b1; iq = 18'd20;
        tick();
        vbits_v_i = 1'b0;
        repeat (15) tick();
        check("bp_second", 80'({r0[0], v0, ovr0, ovr8}), 80'({12'd20, 1'b1, 1'b1, 1'b1}));
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("bp_after_accept", 80'({v0, ovr0}), 80'({1'b0, 1'b1}));
        go_idle();

        // Asynchronous reset mid-epoch with a snapshot pending.
        zero_vb(); enable_i = 1'b1;
        tick();
        vbits_v_i = 1'b1; iq = 18'd1;
        repeat (19) tick();
        check("rst_pre_valid", 80'(v0), 80'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_dut0", 80'(obs0), 80'd0);
        check("rst_async_dut8", 80'(obs8), 80'd0);
        tick();
        tick();
        vbits_v_i = 1'b0; reset = 1'b1;
        tick();
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (v0) begin
                lat = n;
                break;
            end
        end
        check("rst_first_epoch_latency", 80'(lat), 80'd16);
        check("rst_empty_epoch", 80'(obs0), 80'({60'd0, 11'd0, 1'b1, 1'b0, 1'b0}));
        go_idle();

        // Random traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            enable_i    = ($urandom_range(0, 31) != 0);
            vbits_v_i   = 1'($urandom_range(0, 1));
            out_ready_i = ($urandom_range(0, 2) == 0);
            iq = rnd18(); rob = rnd18(); lq = rnd18(); ib = rnd18(); sq = rnd18();
            tick();
            check("rand_dut0", 80'(obs0), 80'(exp_obs(1'b0)));
            check("rand_dut8", 80'(obs8), 80'(exp_obs(1'b1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
